// File: rtl/dcache.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache
// sitting between the CPU load/store port and a Wishbone classic data bus.
module dcache #(
  parameter int          LINES      = 64,
  parameter logic [31:0] CACHE_BASE = 32'h8000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hFF80_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic        cpu_valid_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  input  logic        flush_req_i,
  output logic        flush_done_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_FDONE = 3'd4;

  logic [2:0]       r_state;
  logic [IDX-1:0]   r_cnt;
  logic [LINES-1:0] r_valid;
  logic             r_cached;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [IDX-1:0] w_idx;
  logic [TW-1:0]  w_tag;
  logic           w_cacheable;
  logic           w_hit;
  logic           w_bus;
  logic [IDX-1:0] w_bidx;
  logic [TW-1:0]  w_btag;
  logic           w_fill;
  logic           w_merge;

  assign w_idx       = cpu_addr_i[IDX+1:2];
  assign w_tag       = cpu_addr_i[31:IDX+2];
  assign w_cacheable = (cpu_addr_i & CACHE_MASK) == CACHE_BASE;
  assign w_hit       = cpu_valid_i && (r_state == S_IDLE) && w_cacheable && r_valid[w_idx] &&
                       (r_tag[w_idx] == w_tag) && !cpu_we_i && !flush_req_i;
  assign w_bus       = (r_state == S_RD) || (r_state == S_WR);

  // The bus-side index/tag come from the latched address so a dropped request still fills.
  assign w_bidx  = wb_adr_o[IDX+1:2];
  assign w_btag  = wb_adr_o[31:IDX+2];
  assign w_fill  = (r_state == S_RD) && wb_ack_i && r_cached;
  assign w_merge = (r_state == S_WR) && wb_ack_i && r_cached && r_valid[w_bidx] &&
                   (r_tag[w_bidx] == w_btag);

  assign wb_cyc_o     = w_bus;
  assign wb_stb_o     = w_bus;
  assign flush_done_o = (r_state == S_FDONE);
  assign cpu_ready_o  = w_hit || (w_bus && wb_ack_i && cpu_valid_i);
  assign cpu_rdata_o  = w_hit ? r_data[w_idx] :
                        ((r_state == S_RD) && wb_ack_i && cpu_valid_i) ? wb_dat_i : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_valid  <= '0;
      r_cached <= 1'b0;
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
      wb_sel_o <= 4'd0;
      wb_we_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req_i) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end else if (cpu_valid_i && !w_hit) begin
            r_state  <= cpu_we_i ? S_WR : S_RD;
            wb_adr_o <= {cpu_addr_i[31:2], 2'b00};
            wb_dat_o <= cpu_wdata_i;
            wb_sel_o <= (!cpu_we_i && w_cacheable) ? 4'b1111 : cpu_be_i;
            wb_we_o  <= cpu_we_i;
            r_cached <= w_cacheable;
          end
        end
        S_RD: begin
          if (wb_ack_i) begin
            r_state <= S_IDLE;
            if (r_cached) r_valid[w_bidx] <= 1'b1;
          end
        end
        S_WR: begin
          if (wb_ack_i) r_state <= S_IDLE;
        end
        S_FLUSH: begin
          r_valid[r_cnt] <= 1'b0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == IDX'(LINES - 1)) r_state <= S_FDONE;
        end
        S_FDONE: begin
          if (!flush_req_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; validity alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_bidx]  <= w_btag;
      r_data[w_bidx] <= wb_dat_i;
    end else if (w_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_o[b]) r_data[w_bidx][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Randomized self-checking bench for dcache: a Wishbone slave with programmable wait
// states plus a reference model of memory contents and which word each line holds.
module tb_dcache;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_be_i;
  logic        cpu_valid_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o;
  logic        flush_req_i;
  logic        flush_done_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  dcache dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_we_i(cpu_we_i),
    .cpu_be_i(cpu_be_i), .cpu_valid_i(cpu_valid_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_ready_o(cpu_ready_o), .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave state and transaction record
  logic [31:0] slave_mem [logic [29:0]];
  logic [31:0] ref_mem   [logic [29:0]];
  int          slave_wait = 0;
  int          wcnt = 0;
  int          bus_reads = 0;
  int          bus_writes = 0;
  logic [31:0] last_adr, last_dat;
  logic [3:0]  last_sel;
  logic        last_we;

  // Reference cache: which word address each line currently holds
  bit          m_valid [64];
  logic [29:0] m_waddr [64];

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w[13:0], w[29:12]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'd0;
      wcnt     = 0;
    end else if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'd0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wcnt >= slave_wait) begin
        logic [31:0] cur;
        cur = slave_mem.exists(wb_adr_o[31:2]) ? slave_mem[wb_adr_o[31:2]] : dflt(wb_adr_o[31:2]);
        wb_ack_i = 1'b1;
        wcnt     = 0;
        last_adr = wb_adr_o; last_dat = wb_dat_o; last_sel = wb_sel_o; last_we = wb_we_o;
        if (wb_we_o) begin
          slave_mem[wb_adr_o[31:2]] = merge(cur, wb_dat_o, wb_sel_o);
          bus_writes++;
        end else begin
          wb_dat_i = cur;
          bus_reads++;
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    cpu_valid_i = 1'b0;
    cpu_we_i    = 1'b0;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // One CPU request; expected latency, data and bus activity come from the model.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int wt, input string nm,
                        output logic [31:0] got);
    logic [29:0] wa;
    logic [31:0] exp_rd;
    int idx, exp_lat, lat, br0, bw0;
    bit cach, hit;
    wa      = addr[31:2];
    idx     = int'(addr[7:2]);
    cach    = (addr & 32'hFF80_0000) == 32'h8000_0000;
    hit     = !we && cach && m_valid[idx] && (m_waddr[idx] == wa);
    exp_rd  = ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
    exp_lat = hit ? 0 : wt + 1;
    br0 = bus_reads; bw0 = bus_writes;
    slave_wait = wt;
    @(negedge clk);
    cpu_addr_i = addr; cpu_wdata_i = wd; cpu_we_i = we; cpu_be_i = be; cpu_valid_i = 1'b1;
    #1;
    lat = 0;
    while (!cpu_ready_o && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    got = cpu_rdata_o;
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency addr=%h got=%0d exp=%0d", nm, addr, lat, exp_lat);
    end
    if (!we) begin
      n_checks++;
      if (got !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata addr=%h got=%h exp=%h", nm, addr, got, exp_rd);
      end
    end
    n_checks++;
    if ((bus_reads - br0) != ((!we && !hit) ? 1 : 0) || (bus_writes - bw0) != (we ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s buscount addr=%h reads=%0d writes=%0d hit_exp=%0d", nm, addr,
               bus_reads - br0, bus_writes - bw0, hit);
    end
    if (!hit) begin
      n_checks++;
      if (last_adr !== {addr[31:2], 2'b00} || last_we !== we ||
          last_sel !== ((!we && cach) ? 4'b1111 : be) || (we && last_dat !== wd)) begin
        n_fail++;
        $display("FAIL %s busfields got adr=%h we=%b sel=%b dat=%h exp adr=%h we=%b sel=%b dat=%h",
                 nm, last_adr, last_we, last_sel, last_dat, {addr[31:2], 2'b00}, we,
                 (!we && cach) ? 4'b1111 : be, wd);
      end
    end
    if (we) ref_mem[wa] = merge(exp_rd, wd, be);
    else if (cach && !hit) begin
      m_valid[idx] = 1'b1;
      m_waddr[idx] = wa;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0; cpu_we_i = 1'b0; cpu_be_i = 4'd0;
    cpu_valid_i = 1'b0; flush_req_i = 1'b0;
    model_invalidate();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== 71'd0) begin
        n_fail++;
        $display("FAIL reset_wb pass=%0d got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b exp all 0",
                 k, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
      end
      n_checks++;
      if ({cpu_ready_o, cpu_rdata_o, flush_done_o} !== 34'd0) begin
        n_fail++;
        $display("FAIL reset_cpu pass=%0d got ready=%b rdata=%h done=%b exp 0", k,
                 cpu_ready_o, cpu_rdata_o, flush_done_o);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
    end
  endtask

  task automatic test_directed();
    logic [31:0] got;
    slave_mem[30'h2000_0004] = 32'hDEADBEEF;
    ref_mem[30'h2000_0004]   = 32'hDEADBEEF;
    access(0, 32'h8000_0010, 32'd0, 4'hF, 2, "ld_miss", got);
    access(0, 32'h8000_0010, 32'd0, 4'hF, 0, "ld_hit", got);
    access(1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 1, "st_hit", got);
    access(0, 32'h8000_0010, 32'd0, 4'hF, 0, "ld_merged", got);
    n_checks++;
    if (got !== 32'hDEADABEF) begin
      n_fail++;
      $display("FAIL merged_value got=%h exp=DEADABEF", got);
    end
    access(1, 32'h1000_0000, 32'h1234_5678, 4'hF, 0, "st_uncached", got);
    access(0, 32'h1000_0000, 32'd0, 4'b0011, 1, "ld_uncached1", got);
    access(0, 32'h1000_0000, 32'd0, 4'b0011, 0, "ld_uncached2", got);
    access(0, 32'h8000_0110, 32'd0, 4'hF, 0, "ld_alias", got);
    access(0, 32'h8000_0010, 32'd0, 4'hF, 0, "ld_evicted", got);
    access(0, 32'h807F_FFFC, 32'd0, 4'hF, 0, "ld_top_cached", got);
    access(0, 32'h8080_0000, 32'd0, 4'b0100, 0, "ld_above_region", got);
    access(0, 32'h8080_0000, 32'd0, 4'b0100, 0, "ld_above_again", got);
    idle();
  endtask

  task automatic test_drop_valid();
    logic [31:0] got;
    bit seen;
    seen = 1'b0;
    slave_wait = 2;
    @(negedge clk);
    cpu_addr_i = 32'h8000_0040; cpu_we_i = 1'b0; cpu_be_i = 4'hF; cpu_valid_i = 1'b1;
    @(negedge clk);
    cpu_valid_i = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (wb_ack_i) begin
        seen = 1'b1;
        n_checks++;
        if (cpu_ready_o !== 1'b0 || cpu_rdata_o !== 32'd0) begin
          n_fail++;
          $display("FAIL drop_valid ready=%b rdata=%h exp ready=0 rdata=0", cpu_ready_o, cpu_rdata_o);
        end
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL drop_valid_ack got=none exp=ack within 20 cycles");
    end
    m_valid[16] = 1'b1;
    m_waddr[16] = 30'h2000_0010;
    access(0, 32'h8000_0040, 32'd0, 4'hF, 0, "drop_then_hit", got);
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] got;
    int cnt;
    bit bad_ready;
    access(0, 32'h8000_0000, 32'd0, 4'hF, 1, "fill_l0", got);
    access(0, 32'h8000_0014, 32'd0, 4'hF, 0, "fill_l5", got);
    access(0, 32'h8000_0000, 32'd0, 4'hF, 0, "pre_flush_hit", got);
    idle();
    @(negedge clk);
    flush_req_i = 1'b1;
    cpu_addr_i = 32'h8000_0000; cpu_we_i = 1'b0; cpu_be_i = 4'hF; cpu_valid_i = 1'b1;
    #1;
    bad_ready = cpu_ready_o;
    cnt = 0;
    while (!flush_done_o && cnt < 200) begin
      @(negedge clk); #1;
      cnt++;
      bad_ready |= cpu_ready_o;
    end
    n_checks++;
    if (cnt !== 65) begin
      n_fail++;
      $display("FAIL flush_latency got=%0d exp=65", cnt);
    end
    repeat (3) begin
      @(negedge clk); #1;
      bad_ready |= cpu_ready_o;
    end
    n_checks++;
    if (flush_done_o !== 1'b1 || bad_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hold got done=%b any_ready=%b exp done=1 any_ready=0", flush_done_o, bad_ready);
    end
    @(negedge clk);
    flush_req_i = 1'b0;
    cpu_valid_i = 1'b0;
    model_invalidate();
    access(0, 32'h8000_0000, 32'd0, 4'hF, 1, "post_flush_l0", got);
    access(0, 32'h8000_0014, 32'd0, 4'hF, 0, "post_flush_l5", got);
    idle();
  endtask

  task automatic test_random();
    logic [31:0] got, addr, wd;
    logic [3:0]  be;
    bit          we;
    int          sel;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)
        addr = 32'h8000_0000 | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 7) << 2);
      else if (sel < 9)
        addr = 32'h1000_0000 | ($urandom_range(0, 3) << 2);
      else
        addr = 32'h807F_FFFC;
      addr[1:0] = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      access(we, addr, wd, be, $urandom_range(0, 3), "random", got);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
  endtask

  task automatic test_reset_mid_bus();
    logic [31:0] got;
    int br0;
    br0 = bus_reads;
    slave_wait = 6;
    @(negedge clk);
    cpu_addr_i = 32'h8000_0020; cpu_we_i = 1'b0; cpu_be_i = 4'hF; cpu_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cpu_ready_o !== 1'b0 || bus_reads != br0) begin
      n_fail++;
      $display("FAIL reset_mid_bus got cyc=%b stb=%b ready=%b acks=%0d exp 0 0 0 0",
               wb_cyc_o, wb_stb_o, cpu_ready_o, bus_reads - br0);
    end
    @(negedge clk);
    cpu_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_invalidate();
    access(0, 32'h8000_0020, 32'd0, 4'hF, 0, "after_reset_miss", got);
    access(0, 32'h8000_0020, 32'd0, 4'hF, 0, "after_reset_hit", got);
    idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_drop_valid();
    test_flush();
    test_random();
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
